// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_DATA_W = 10;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

  // True when an index names a real, writable/trackable register.
  function automatic logic idx_ok(
    input int unsigned idx,
    input int unsigned depth,
    input logic        zero_reg
  );
    return (idx < depth) && !(zero_reg && (idx == 0));
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the scoreboarded register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              rd_valid;
  logic              we;
  logic [ADDR_W-1:0] ws;
  logic [DATA_W-1:0] wd;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_idx;
  logic              busy1;
  logic              busy2;

  modport master (
    output rd_en, rs1, rs2, we, ws, wd,
    output sb_set, sb_idx,
    input  rd1, rd2, rd_valid, busy1, busy2
  );

  modport slave (
    input  rd_en, rs1, rs2, we, ws, wd,
    input  sb_set, sb_idx,
    output rd1, rd2, rd_valid, busy1, busy2
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              busy1,
  output logic              busy2
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             set_ok;

  always_comb begin
    busy_d = busy_q;
    set_ok = set_en && idx_ok(32'(set_idx), DEPTH, ZR);
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // set applied last so it wins a same-index collision
    if (set_ok) busy_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (idx_ok(32'(rs1), DEPTH, ZR)) busy1 = busy_q[rs1];
    if (idx_ok(32'(rs2), DEPTH, ZR)) busy2 = busy_q[rs2];
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file, registered reads, write-first bypass.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam logic ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ok;
  logic [DATA_W-1:0] eff1, eff2;

  always_comb begin
    wr_ok  = bus.we && idx_ok(32'(bus.ws), DEPTH, ZR);
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.ws] = bus.wd;
  end

  always_comb begin
    eff1 = '0;
    eff2 = '0;
    if (idx_ok(32'(bus.rs1), DEPTH, ZR)) begin
      if (wr_ok && bus.ws == bus.rs1) eff1 = bus.wd;
      else                            eff1 = regs_q[bus.rs1];
    end
    if (idx_ok(32'(bus.rs2), DEPTH, ZR)) begin
      if (wr_ok && bus.ws == bus.rs2) eff2 = bus.wd;
      else                            eff2 = regs_q[bus.rs2];
    end
  end

  always_comb begin
    rd1_d      = bus.rd_en ? eff1 : rd1_q;
    rd2_d      = bus.rd_en ? eff2 : rd2_q;
    rd_valid_d = bus.rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd1      = rd1_q;
  assign bus.rd2      = rd2_q;
  assign bus.rd_valid = rd_valid_q;

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_en (wr_ok),
    .clr_idx(bus.ws),
    .set_en (bus.sb_set),
    .set_idx(bus.sb_idx),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .busy1  (bus.busy1),
    .busy2  (bus.busy2)
  );

endmodule
